// File: rtl/nios_timer_pkg.sv
// Shared definitions for the multi-channel interval timer.
// Register map, control/status bit positions, address sizing.
package nios_timer_pkg;

   localparam int OFF_W = 3;

   localparam logic [2:0] OFF_STATUS   = 3'd0;
   localparam logic [2:0] OFF_CONTROL  = 3'd1;
   localparam logic [2:0] OFF_PERIOD   = 3'd2;
   localparam logic [2:0] OFF_SNAPSHOT = 3'd3;
   localparam logic [2:0] OFF_PRESCALE = 3'd4;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   localparam int STAT_TO  = 0;
   localparam int STAT_RUN = 1;

   typedef struct packed {
      logic run;
      logic to;
   } ch_status_t;

   typedef struct packed {
      logic cont;
      logic ito;
   } ch_ctrl_t;

   function automatic int addr_w(input int num_ch);
      return $clog2(num_ch) + OFF_W;
   endfunction

endpackage

// File: rtl/nios_timer_channel.sv
// One timer channel: prescaler, down-counter, flags and its registers.
// Read data is combinational; the top registers it.
module nios_timer_channel
   import nios_timer_pkg::*;
#(
   parameter int          CNT_W        = 32,
   parameter int          PRE_W        = 8,
   parameter int unsigned RESET_PERIOD = 49999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [2:0]  offset,
   input  logic [31:0] writedata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

   ch_status_t       st;
   ch_ctrl_t         ctl;
   logic             load_pend;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] snapshot;
   logic [PRE_W-1:0] prescale;
   logic [PRE_W-1:0] prescaler;

   logic wr_status;
   logic wr_ctrl;
   logic wr_period;
   logic wr_snap;
   logic wr_pre;
   logic tick;
   logic expire;
   logic do_start;
   logic do_stop;

   assign wr_status = wr_en && (offset == OFF_STATUS);
   assign wr_ctrl   = wr_en && (offset == OFF_CONTROL);
   assign wr_period = wr_en && (offset == OFF_PERIOD);
   assign wr_snap   = wr_en && (offset == OFF_SNAPSHOT);
   assign wr_pre    = wr_en && (offset == OFF_PRESCALE);

   assign do_start = wr_ctrl && writedata[CTRL_START];
   assign do_stop  = wr_ctrl && writedata[CTRL_STOP];

   assign tick   = st.run && (prescaler == '0);
   assign expire = tick && (counter == '0);

   assign irq = st.to && ctl.ito;

   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= '0;
         ctl       <= '0;
         load_pend <= 1'b0;
         period    <= RST_VAL;
         counter   <= RST_VAL;
         snapshot  <= '0;
         prescale  <= '0;
         prescaler <= '0;
      end else begin
         if (wr_period)
            st.run <= 1'b0;
         else if (do_start)
            st.run <= 1'b1;
         else if (do_stop)
            st.run <= 1'b0;
         else if (expire && !ctl.cont)
            st.run <= 1'b0;

         // a timeout landing with a clear keeps the flag set
         if (expire)
            st.to <= 1'b1;
         else if (wr_status)
            st.to <= 1'b0;

         if (wr_ctrl) begin
            ctl.cont <= writedata[CTRL_CONT];
            ctl.ito  <= writedata[CTRL_ITO];
         end

         load_pend <= wr_period;
         if (wr_period)
            period <= writedata[CNT_W-1:0];

         if (load_pend)
            counter <= period;
         else if (tick)
            counter <= expire ? period : counter - CNT_W'(1);

         if (wr_pre) begin
            prescale  <= writedata[PRE_W-1:0];
            prescaler <= writedata[PRE_W-1:0];
         end else if (load_pend || tick) begin
            prescaler <= prescale;
         end else if (st.run) begin
            prescaler <= prescaler - PRE_W'(1);
         end

         if (wr_snap)
            snapshot <= counter;
      end
   end

   always_comb begin
      rdata = '0;
      unique case (offset)
         OFF_STATUS:   rdata = 32'(st);
         OFF_CONTROL:  rdata = 32'(ctl);
         OFF_PERIOD:   rdata = 32'(period);
         OFF_SNAPSHOT: rdata = 32'(snapshot);
         OFF_PRESCALE: rdata = 32'(prescale);
         default:      rdata = '0;
      endcase
   end

endmodule

// File: rtl/nios_multi_timer.sv
// Multi-channel timer slave: address decode, channel array, read mux.
// Address is {channel index, register offset}.
module nios_multi_timer
   import nios_timer_pkg::*;
#(
   parameter int          NUM_CH       = 4,
   parameter int          CNT_W        = 32,
   parameter int          PRE_W        = 8,
   parameter int unsigned RESET_PERIOD = 49999,
   localparam int         ADDR_W       = addr_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [NUM_CH-1:0] irq_vec,
   output logic              irq
);

   logic [3:0]  ch_idx;
   logic        ch_ok;
   logic        bus_wr;
   logic [31:0] ch_rd [NUM_CH];
   logic [31:0] rd_mux;

   if (ADDR_W > OFF_W) begin : g_idx
      assign ch_idx = 4'(address[ADDR_W-1:OFF_W]);
   end else begin : g_idx0
      assign ch_idx = '0;
   end

   assign ch_ok  = ch_idx < 4'(NUM_CH);
   assign bus_wr = chipselect && !write_n;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      nios_timer_channel #(
         .CNT_W        (CNT_W),
         .PRE_W        (PRE_W),
         .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .wr_en     (bus_wr && (ch_idx == 4'(i))),
         .offset    (address[2:0]),
         .writedata (writedata),
         .rdata     (ch_rd[i]),
         .irq       (irq_vec[i])
      );
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_idx == 4'(i))
            rd_mux = ch_rd[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         readdata <= '0;
      else
         readdata <= ch_ok ? rd_mux : '0;
   end

   assign irq = |irq_vec;

endmodule

// File: tb/tb_nios_multi_timer.sv
// Bench for nios_multi_timer with three channels.
// Reference model plus directed scenarios.
module tb_nios_multi_timer;

   localparam int NC = 3;

   logic        clk;
   logic        reset;
   logic        chipselect;
   logic        write_n;
   logic [4:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [2:0]  irq_vec;
   logic        irq;

   int n_chk  = 0;
   int n_fail = 0;

   nios_multi_timer #(
      .NUM_CH       (NC),
      .CNT_W        (32),
      .PRE_W        (8),
      .RESET_PERIOD (49999)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .chipselect (chipselect),
      .write_n    (write_n),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq_vec    (irq_vec),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state, one entry per channel
   bit          m_run  [NC];
   bit          m_to   [NC];
   bit          m_cont [NC];
   bit          m_ito  [NC];
   bit          m_pend [NC];
   int unsigned m_per  [NC];
   int unsigned m_cnt  [NC];
   int unsigned m_snap [NC];
   int unsigned m_pre  [NC];
   int unsigned m_psc  [NC];

   bit          mvalid = 0;
   logic [31:0] exp_rd;
   logic [2:0]  exp_irqv;

   bit          hit, tick, tmo, bw;
   logic [2:0]  off;
   int unsigned o_cnt;
   bit          o_pend;

   function automatic logic [31:0] model_read(input logic [4:0] a);
      int c;
      c = int'(a[4:3]);
      if (c >= NC) return 32'd0;
      case (a[2:0])
         3'd0: return {30'd0, m_run[c], m_to[c]};
         3'd1: return {30'd0, m_cont[c], m_ito[c]};
         3'd2: return m_per[c];
         3'd3: return m_snap[c];
         3'd4: return m_pre[c];
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      mvalid = 1;
      if (reset) begin
         exp_rd = 32'd0;
         for (int c = 0; c < NC; c++) begin
            m_run[c] = 0; m_to[c] = 0;
            m_cont[c] = 0; m_ito[c] = 0;
            m_pend[c] = 0;
            m_per[c] = 49999; m_cnt[c] = 49999;
            m_snap[c] = 0; m_pre[c] = 0; m_psc[c] = 0;
         end
      end else begin
         exp_rd = model_read(address);
         bw = chipselect && !write_n;
         off = address[2:0];
         for (int c = 0; c < NC; c++) begin
            hit = bw && (int'(address[4:3]) == c);
            tick = m_run[c] && (m_psc[c] == 0);
            tmo = tick && (m_cnt[c] == 0);
            o_cnt = m_cnt[c];
            o_pend = m_pend[c];
            if (o_pend)
               m_cnt[c] = m_per[c];
            else if (tick)
               m_cnt[c] = tmo ? m_per[c] : o_cnt - 1;
            if (hit && off == 4)
               m_psc[c] = writedata & 32'hFF;
            else if (o_pend || tick)
               m_psc[c] = m_pre[c];
            else if (m_run[c])
               m_psc[c] = m_psc[c] - 1;
            if (hit && off == 2)
               m_run[c] = 0;
            else if (hit && off == 1 && writedata[2])
               m_run[c] = 1;
            else if (hit && off == 1 && writedata[3])
               m_run[c] = 0;
            else if (tmo && !m_cont[c])
               m_run[c] = 0;
            if (tmo)
               m_to[c] = 1;
            else if (hit && off == 0)
               m_to[c] = 0;
            if (hit && off == 1) begin
               m_cont[c] = writedata[1];
               m_ito[c]  = writedata[0];
            end
            m_pend[c] = hit && off == 2;
            if (hit && off == 2) m_per[c] = writedata;
            if (hit && off == 3) m_snap[c] = o_cnt;
            if (hit && off == 4) m_pre[c] = writedata & 32'hFF;
         end
      end
      for (int c = 0; c < NC; c++)
         exp_irqv[c] = m_to[c] && m_ito[c];
   end

   always @(negedge clk) begin
      if (mvalid) begin
         n_chk++;
         if (readdata !== exp_rd) begin
            n_fail++;
            $display("FAIL cyc_readdata t=%0t act=%h exp=%h",
                     $time, readdata, exp_rd);
         end
         n_chk++;
         if (irq_vec !== exp_irqv) begin
            n_fail++;
            $display("FAIL cyc_irq_vec t=%0t act=%b exp=%b",
                     $time, irq_vec, exp_irqv);
         end
         n_chk++;
         if (irq !== (|exp_irqv)) begin
            n_fail++;
            $display("FAIL cyc_irq t=%0t act=%b exp=%b",
                     $time, irq, |exp_irqv);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      @(negedge clk);
      v = readdata;
      chipselect = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_irq(input int ch, input int budget, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!irq_vec[ch] && k < budget);
   endtask

   logic [31:0] v;
   int k, k2;

   initial begin
      reset      = 1'b1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = '0;
      writedata  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // reset state
      rd(5'd2, v);
      chk("rst_period", v, 32'd49999);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      rd(5'd0, v);
      chk("rst_status", v, 32'd0);

      // ch1 continuous, period 3, prescale 0
      wr(5'd10, 32'd3);
      wr(5'd12, 32'd0);
      wr(5'd9, 32'h7);
      wait_irq(1, 10, k);
      chk("ch1_first_to", k, 32'd4);
      wr(5'd8, 32'd0);
      chk("ch1_cleared", {31'd0, irq_vec[1]}, 32'd0);
      chk("ch1_irq_follow", {31'd0, irq}, 32'd0);
      wait_irq(1, 10, k2);
      chk("ch1_interval", 1 + k2, 32'd4);
      chk("ch1_irq_high", {31'd0, irq}, 32'd1);
      wr(5'd8, 32'd0);
      wr(5'd9, 32'h8);

      // ch2 one-shot, period 2, prescale 1
      wr(5'd18, 32'd2);
      wr(5'd20, 32'd1);
      wr(5'd17, 32'h5);
      wait_irq(2, 12, k);
      chk("ch2_oneshot_at", k, 32'd6);
      rd(5'd16, v);
      chk("ch2_status", v, 32'd1);
      wr(5'd16, 32'd0);
      wr(5'd19, 32'd0);
      rd(5'd19, v);
      chk("ch2_counter", v, 32'd2);
      idle(8);
      chk("ch2_no_second", {29'd0, irq_vec}, 32'd0);

      // clear racing a timeout, then start+stop
      wr(5'd10, 32'd3);
      wr(5'd8, 32'd0);
      wr(5'd9, 32'h7);
      idle(3);
      wr(5'd8, 32'd0);
      chk("race_to_kept", {31'd0, irq_vec[1]}, 32'd1);
      rd(5'd8, v);
      chk("race_status", v, 32'd3);
      wr(5'd9, 32'h8);
      wr(5'd9, 32'hC);
      rd(5'd8, v);
      chk("start_wins", {31'd0, v[1]}, 32'd1);

      // ch0 period rewrite while running
      wr(5'd1, 32'h6);
      idle(4);
      wr(5'd2, 32'd100);
      rd(5'd0, v);
      chk("ch0_stopped", {31'd0, v[1]}, 32'd0);
      wr(5'd3, 32'd0);
      rd(5'd3, v);
      chk("ch0_snapshot", v, 32'd100);

      // window of nonexistent channel 3 and unused offsets
      for (int o = 0; o < 8; o++) begin
         wr(5'(24 + o), 32'h55);
         rd(5'(24 + o), v);
         chk("ch3_window", v, 32'd0);
      end
      rd(5'd2, v);
      chk("ch0_untouched", v, 32'd100);
      rd(5'd18, v);
      chk("ch2_untouched", v, 32'd2);
      wr(5'd5, 32'hFFFF);
      rd(5'd5, v);
      chk("off5_zero", v, 32'd0);

      // reset overrides a concurrent bus write
      reset = 1'b1;
      wr(5'd2, 32'd7);
      reset = 1'b0;
      rd(5'd2, v);
      chk("rst_override", v, 32'd49999);
      rd(5'd10, v);
      chk("rst_ch1_period", v, 32'd49999);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/nios_multi_timer.md
NIOS_MULTI_TIMER -- requirements
Module: nios_multi_timer

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 Parameter CNT_W, default 32, counter/period width in bits (8..32).
REQ-003 Parameter PRE_W, default 8, per-channel prescaler width in bits.
REQ-004 Parameter RESET_PERIOD, default 49999, reset value of every period register and counter.
REQ-005 Derived ADDR_W = clog2(NUM_CH)+3; address = {channel index, register offset[2:0]}.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  reset, synchronous and active-high.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-010 address  input  ADDR_W  word address.
REQ-011 writedata  input  32  write data.
REQ-012 readdata  output  32  registered read data.
REQ-013 irq_vec  output  NUM_CH  per-channel interrupt = timeout flag AND interrupt-enable bit.
REQ-014 irq  output  1  OR of irq_vec.

Function
REQ-015 Register offsets per channel SHALL be: 0 status {run, to}; 1 control {stop[3], start[2], cont[1], ito[0]}; 2 period[CNT_W-1:0]; 3 snapshot; 4 prescale[PRE_W-1:0]; offsets 5..7 SHALL read 0 and ignore writes.
REQ-016 Channel index >= NUM_CH SHALL read 0 and ignore writes.
REQ-017 readdata SHALL update every cycle with the addressed register, one-cycle latency; unused upper bits SHALL read 0.
REQ-018 Control write SHALL store bits [1:0]; bits [3:2] act as strobes; start and stop in the same write: start wins.
REQ-019 Prescaler SHALL count down from the prescale value; a tick occurs when it is 0 while running, then it reloads; prescale 0 gives a tick every clock.
REQ-020 On a tick with counter != 0, the counter SHALL decrement by 1.
REQ-021 On a tick with counter == 0, the counter SHALL reload from period, set the to flag, and clear run if cont = 0.
REQ-022 A period write SHALL stop the channel and, on the next cycle, load counter from the new period and reset the prescaler.
REQ-023 A write of any data to status SHALL clear the to flag; a same-cycle timeout SHALL win (flag stays 1).
REQ-024 A write to snapshot SHALL capture the current counter value; reads return the captured value.
REQ-025 Period 0 in continuous mode SHALL raise a timeout on every tick.
REQ-026 Channels SHALL be fully independent; simultaneous timeouts on several channels SHALL each set their own flag.

Reset
REQ-027 Reset SHALL set:
- readdata, control, status flags, snapshot, prescale, prescaler to 0;
- period and counter to RESET_PERIOD truncated to CNT_W;
- irq and irq_vec low.
REQ-028 Reset asserted mid-count SHALL override all bus writes in that cycle.

Structure
REQ-029 Package nios_timer_pkg SHALL hold register offsets, control/status bit positions, and the ADDR_W derivation function.
REQ-030 Sub-module nios_timer_channel SHALL implement one channel: prescaler, counter, flags, and per-channel registers. It is instantiated NUM_CH times under a top that decodes the address and muxes reads.

Verification
REQ-031 Reset, then read ch0 period (address 2) -> readdata 49999 one cycle after the read address is presented; irq = 0.
REQ-032 ch1: period 3, prescale 0, control 0x7 (start, cont, ito) -> irq_vec[1] rises every 4 clocks; status write clears it; irq follows.
REQ-033 ch2: period 2, prescale 1, control 0x5 (one-shot) -> exactly one timeout after 6 clocks; run = 0 afterward; counter holds 2.
REQ-034 Status write in the same cycle as a timeout -> to stays 1; control write 0xC (start+stop) -> run = 1.
REQ-035 Running ch0: write period 100 -> run = 0 next cycle; snapshot write then read -> 100.
REQ-036 NUM_CH=3: write/read to channel 3 address window -> readdata 0; no channel state changes.
